// File: rtl/activation_arbiter.sv
// Round-robin arbiter sharing one activation unit among N_REQ lanes.
// Issued operands are tagged, captured ACT_LAT cycles later and returned through a FWFT FIFO.
module activation_arbiter #(
  parameter int N_REQ      = 4,
  parameter int W_IN       = 8,
  parameter int W_OUT      = 9,
  parameter int ACT_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*W_IN-1:0]   req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [W_IN-1:0]         act_in,
  input  logic [W_OUT-1:0]        act_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [W_OUT-1:0]        res_data,
  output logic [ID_W-1:0]         res_id,
  output logic                    busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] idx;
  logic            found;
  logic            issue_ok;
  logic            issue;
  logic            capture;
  logic            pop;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;

  logic [ACT_LAT-1:0] tag_v;
  logic [ID_W-1:0]    tag_id [ACT_LAT];

  logic [W_OUT-1:0] mem_data [FIFO_DEPTH];
  logic [ID_W-1:0]  mem_id   [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // First requesting lane at or after ptr, cyclically; ptr width gives the wrap for free.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + ID_W'(k);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign occupancy = {1'b0, inflight} + {1'b0, count};
  assign issue_ok  = occupancy < (CW+1)'(FIFO_DEPTH);
  assign issue     = found && issue_ok && !reset;
  assign req_ready = issue ? (N_REQ'(1) << winner) : '0;
  assign capture   = tag_v[ACT_LAT-1];
  assign res_valid = (count != '0);
  assign pop       = res_valid && res_ready;
  assign res_data  = res_valid ? mem_data[rd_ptr] : '0;
  assign res_id    = res_valid ? mem_id[rd_ptr] : '0;
  assign busy      = (inflight != '0) || (count != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      act_in   <= '0;
      inflight <= '0;
      tag_v    <= '0;
      for (int s = 0; s < ACT_LAT; s++) tag_id[s] <= '0;
    end else begin
      if (issue) begin
        act_in <= req_data[winner*W_IN +: W_IN];
        ptr    <= winner + ID_W'(1);
      end
      tag_v[0]  <= issue;
      tag_id[0] <= winner;
      for (int s = 1; s < ACT_LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
      inflight <= inflight + CW'(issue) - CW'(capture);
    end
  end

  // issue_ok bounds inflight+count, so a capture always finds a free slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (capture) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(capture) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (capture) begin
      mem_data[wr_ptr] <= act_out;
      mem_id[wr_ptr]   <= tag_id[ACT_LAT-1];
    end
  end

endmodule

// File: tb/tb_activation_arbiter.sv
// Self-checking bench for activation_arbiter: reference arbitration model plus result scoreboard.
// The shared unit is a stub returning sign-extended operand + 1.
module tb_activation_arbiter;

  localparam int N  = 4;
  localparam int WI = 8;
  localparam int WO = 9;
  localparam int FD = 4;

  typedef struct packed {
    logic [1:0]    id;
    logic [WO-1:0] data;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*WI-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [WI-1:0] act_in;
  logic [WO-1:0] act_out;
  logic          res_valid;
  logic          res_ready;
  logic [WO-1:0] res_data;
  logic [1:0]    res_id;
  logic          busy;

  int   n_cmp = 0;
  int   n_err = 0;
  int   m_ptr, m_inflight, m_count;
  bit   m_pipe;
  bit   auto_drop;
  exp_t sb[$];
  int   grants[$];

  always #5 clock = ~clock;

  function automatic logic [WO-1:0] stub(input logic [WI-1:0] d);
    return {d[WI-1], d} + 9'd1;
  endfunction

  assign act_out = stub(act_in);

  activation_arbiter #(
    .N_REQ(N), .W_IN(WI), .W_OUT(WO), .ACT_LAT(1), .FIFO_DEPTH(FD)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .act_in(act_in), .act_out(act_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int lane, input logic [WI-1:0] d);
    req_data[lane*WI +: WI] = d;
    req_valid[lane] = 1'b1;
  endtask

  // One clock: check against the model before the edge, advance the model after it.
  task automatic cycle();
    int g;
    logic [N-1:0] erdy;
    bit ok, iss, pop, cap;
    exp_t e;
    #1;
    ok = (m_inflight + m_count) < FD;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    erdy = '0;
    if (g >= 0 && ok) erdy[g] = 1'b1;
    iss = (erdy != '0);
    check("req_ready", req_ready, erdy);
    check("res_valid", res_valid, m_count != 0);
    check("busy", busy, (m_inflight != 0) || (m_count != 0));
    if (iss) begin
      e.id   = g[1:0];
      e.data = stub(req_data[g*WI +: WI]);
      sb.push_back(e);
      grants.push_back(g);
    end
    pop = (m_count != 0) && res_ready;
    if (pop) begin
      e = sb.pop_front();
      check("res_data", res_data, e.data);
      check("res_id", res_id, e.id);
    end
    @(posedge clock);
    cap = m_pipe;
    m_pipe = iss;
    m_inflight += int'(iss) - int'(cap);
    m_count += int'(cap) - int'(pop);
    if (iss) m_ptr = (g + 1) % N;
    @(negedge clock);
    if (iss && auto_drop) req_valid[g] = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_id", res_id, 0);
    check("rst_busy", busy, 0);
    check("rst_act_in", act_in, 0);
    m_ptr = 0; m_inflight = 0; m_count = 0; m_pipe = 0;
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int s;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b1;
    auto_drop = 1'b1;
    apply_reset();

    // Full contention: grants 0..3 in order, results 0x002..0x005.
    for (int i = 0; i < N; i++) set_lane(i, WI'(i + 1));
    s = grants.size();
    run(7);
    check("contend_count", grants.size() - s, 4);
    for (int i = 0; i < 4; i++) check("contend_grant", grants[s + i], i);

    // Single issue on lane 2.
    set_lane(2, 8'h10);
    cycle();
    cycle();
    check("single_data", res_data, 9'h011);
    check("single_id", res_id, 2);
    run(2);

    // Most negative operand on lane 1.
    set_lane(1, 8'h80);
    cycle();
    cycle();
    check("neg_data", res_data, 9'h181);
    check("neg_id", res_id, 1);
    run(2);

    // Backpressure: four issues fill the buffer, one pop lets one more in.
    auto_drop = 1'b0;
    res_ready = 1'b0;
    for (int i = 0; i < N; i++) set_lane(i, WI'(8'h20 + i));
    s = grants.size();
    run(6);
    check("bp_issues", grants.size() - s, 4);
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
    s = grants.size();
    run(2);
    check("bp_resume", grants.size() - s, 1);
    req_valid = '0;
    res_ready = 1'b1;
    run(8);

    // Fairness between lanes 0 and 3.
    set_lane(0, 8'h7f);
    set_lane(3, 8'hfe);
    s = grants.size();
    run(8);
    for (int i = s + 1; i < grants.size(); i++)
      check("fair_alt", grants[i], (grants[i-1] == 0) ? 3 : 0);
    req_valid = '0;
    run(4);

    // Reset with two results buffered and one in flight, pointer left non-zero.
    auto_drop = 1'b1;
    res_ready = 1'b0;
    set_lane(0, 8'h11);
    set_lane(1, 8'h22);
    set_lane(2, 8'h33);
    run(3);
    check("pre_rst_count", m_count, 2);
    check("pre_rst_res_valid", res_valid, 1);
    req_valid = 4'b1111;
    apply_reset();
    req_valid = '0;
    res_ready = 1'b1;
    set_lane(0, 8'h55);
    set_lane(3, 8'hf0);
    s = grants.size();
    cycle();
    check("post_rst_first_grant", grants[s], 0);
    cycle();
    check("post_rst_data", res_data, 9'h056);
    check("post_rst_id", res_id, 0);
    run(5);
    check("final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
